instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the 8-bit address PCa into the asynchronous-read Instrction_Memory.
- Captures the returned 16-bit word Oi into a small prefetch buffer and presents it to decode with a valid/ready handshake.
- Handles start/halt control and branch redirects, flushing the buffer on a redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned IW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 2;

  localparam logic [AW_DEF-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding {pc, instr} pairs; flush overrides push and pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned W     = AW_DEF + IW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the pc, drives the instruction memory address,
// buffers returned words and hands them to decode with valid/ready.
// Optional macro FETCH_WRAP_TRAP_EN: halt and flag wrap_err after fetching
// the last address instead of silently wrapping the pc.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   IW       = IW_DEF,
  parameter int unsigned   DEPTH    = DEPTH_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] PCa,
  input  logic [IW-1:0] Oi,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          fetching
`ifdef FETCH_WRAP_TRAP_EN
  ,
  output logic          wrap_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = AW + IW;

  fetch_state_t  r_state;
  logic [AW-1:0] r_pc;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_start;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [EW-1:0] w_head;

`ifdef FETCH_WRAP_TRAP_EN
  logic r_wrap_err;

  assign wrap_err = r_wrap_err;
  assign w_start  = start && !r_wrap_err;
`else
  assign w_start  = start;
`endif

  // Fetch handshake: memory is combinational, so a push captures Oi for the current pc.
  assign w_pop  = !w_empty && instr_ready;
  assign w_room = (w_count < CW'(DEPTH)) || w_pop;
  assign w_push = (r_state == ST_FETCH) && !br_taken && w_room;

  assign PCa         = r_pc;
  assign instr       = w_head[IW-1:0];
  assign instr_pc    = w_head[EW-1:IW];
  assign instr_valid = !w_empty;
  assign fetching    = (r_state == ST_FETCH);

  fetch_buffer #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (br_taken),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_pc, Oi}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // pc and control FSM; a redirect replaces the pc and freezes the state for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= ST_IDLE;
`ifdef FETCH_WRAP_TRAP_EN
      r_wrap_err <= 1'b0;
`endif
    end else if (br_taken) begin
      r_pc <= br_target;
`ifdef FETCH_WRAP_TRAP_EN
      r_wrap_err <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_pc <= r_pc + AW'(1);
      end
      case (r_state)
        ST_IDLE, ST_HALTED: if (w_start && !halt) r_state <= ST_FETCH;
        ST_FETCH:           if (halt) r_state <= ST_HALTED;
        default:            r_state <= ST_IDLE;
      endcase
`ifdef FETCH_WRAP_TRAP_EN
      if (w_push && (r_pc == '1)) begin
        r_state    <= ST_HALTED;
        r_wrap_err <= 1'b1;
      end
`endif
    end
  end

  // Full flag and occupancy count must always agree.
  assert property (@(posedge clk) disable iff (rst) w_full == (w_count == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 2;

  localparam int S_IDLE   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_HALTED = 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] w;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [AW-1:0] PCa;
  logic [IW-1:0] Oi;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          fetching;
`ifdef FETCH_WRAP_TRAP_EN
  logic          wrap_err;
`endif

  logic [IW-1:0] imem [256];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  int            m_st;
  bit            m_werr;
  ent_t          mq[$];
  ent_t          sb[$];

  always #5 clk = ~clk;

  assign Oi = imem[PCa];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .PCa         (PCa),
    .Oi          (Oi),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetching    (fetching)
`ifdef FETCH_WRAP_TRAP_EN
    ,
    .wrap_err    (wrap_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge from the specified rules.
  always @(posedge clk) begin : model
    bit   pop;
    bit   push;
    ent_t e;
    if (rst) begin
      m_pc   = 8'h00;
      m_st   = S_IDLE;
      m_werr = 1'b0;
      mq.delete();
      sb.delete();
    end else if (br_taken) begin
      m_pc   = br_target;
      m_werr = 1'b0;
      mq.delete();
      sb.delete();
    end else begin
      pop  = (mq.size() != 0) && instr_ready;
      push = (m_st == S_FETCH) && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (m_st == S_FETCH && halt) m_st = S_HALTED;
      else if (m_st != S_FETCH && start && !halt && !m_werr) m_st = S_FETCH;
      if (push) begin
        e.pc = m_pc;
        e.w  = imem[m_pc];
        mq.push_back(e);
        sb.push_back(e);
`ifdef FETCH_WRAP_TRAP_EN
        if (m_pc == 8'hFF) begin
          m_st   = S_HALTED;
          m_werr = 1'b1;
        end
`endif
        m_pc = m_pc + 8'd1;
      end
    end
  end

  // Monitor: compares DUT outputs against the model and scoreboard on falling edges.
  always @(negedge clk) begin : monitor
    ent_t e;
    chk("PCa", 32'(PCa), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    chk("fetching", 32'(fetching), 32'(m_st == S_FETCH));
`ifdef FETCH_WRAP_TRAP_EN
    chk("wrap_err", 32'(wrap_err), 32'(m_werr));
`endif
    if (instr_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow: DUT valid pc %0h but no entry expected at %0t", instr_pc, $time);
      end else begin
        e = sb[0];
        chk("instr_pc", 32'(instr_pc), 32'(e.pc));
        chk("instr", 32'(instr), 32'(e.w));
        if (instr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start    = 1'b0;
      halt     = 1'b0;
      br_taken = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    rst = 1'b1; start = 1'b0; halt = 1'b0; br_taken = 1'b0;
    br_target = '0; instr_ready = 1'b1;
    tick(2);
    chk("reset_instr", 32'(instr), 32'h0);
    chk("reset_instr_pc", 32'(instr_pc), 32'h0);
    rst = 1'b0;

    // Streaming fetch from reset
    start = 1'b1; tick(1); tick(8);

    // Backpressure then release
    rst = 1'b1; tick(1); rst = 1'b0;
    instr_ready = 1'b0; start = 1'b1; tick(1); tick(5);
    instr_ready = 1'b1; tick(6);

    // Redirect while full
    instr_ready = 1'b0; tick(3);
    br_taken = 1'b1; br_target = 8'd84; tick(1);
    instr_ready = 1'b1; tick(5);

    // Redirect together with a pop
    br_taken = 1'b1; br_target = 8'd42; tick(1); tick(3);

    // Halt, drain, resume, mid-stream reset
    br_taken = 1'b1; br_target = 8'd30; tick(1); tick(4);
    instr_ready = 1'b0; tick(1); halt = 1'b1; tick(1);
    instr_ready = 1'b1; tick(4);
    start = 1'b1; tick(1); tick(4);
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    start = 1'b1; tick(1); tick(3);

    // Top-of-address-space fetch
    br_taken = 1'b1; br_target = 8'hFE; tick(1); tick(6);
    start = 1'b1; tick(1); tick(3);
    br_taken = 1'b1; br_target = 8'd15; tick(1);
    start = 1'b1; tick(1); tick(4);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 7) == 0);
      halt        = ($urandom_range(0, 19) == 0);
      br_taken    = ($urandom_range(0, 24) == 0);
      br_target   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; start = 1'b0; halt = 1'b0; br_taken = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
